core_mem_responder: RTL
=======================

CORE_MEM_RESPONDER -- requirements
Module: core_mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: byte address width on the core memory protocol.
REQ-002 Parameter DATA_WIDTH, default 32: data width; byte lanes = DATA_WIDTH/8.
REQ-003 Parameter MEM_WORDS, default 1024: number of DATA_WIDTH words of backing storage (power of two).
REQ-004 Parameter GNT_DELAY, default 0: cycles a request is held before grant (0..15).
REQ-005 Parameter RVALID_DELAY, default 1: cycles from grant to rvalid (1..15).
REQ-006 Ports, one per line (name, direction, width, meaning):
  clk  in  1  single clock, all state on rising edge
  rst_n  in  1  asynchronous, active-low reset
  data_req_i  in  1  request from initiator (cache miss port)
  data_gnt_o  out  1  request accepted this cycle
  data_rvalid_o  out  1  response valid (reads and writes)
  data_addr_i  in  ADDR_WIDTH  byte address
  data_we_i  in  1  1 = write, 0 = read
  data_be_i  in  DATA_WIDTH/8  byte enables
  data_rdata_o  out  DATA_WIDTH  read data, meaningful only with rvalid
  data_wdata_i  in  DATA_WIDTH  write data

Function
REQ-007 Block SHALL be the responder (memory side) of the req/gnt/rvalid core memory protocol.
REQ-008 FSM states SHALL be IDLE, GNT_WAIT, RESP_WAIT; at most one granted transaction outstanding.
REQ-009 IDLE: req_i=1 with GNT_DELAY=0 -> gnt_o=1 combinationally same cycle; with GNT_DELAY>0 -> GNT_WAIT, counter cleared.
REQ-010 GNT_WAIT: counter increments per cycle with req_i=1; gnt_o=1 in the cycle counter equals GNT_DELAY.
REQ-011 req_i dropping before grant (protocol violation) SHALL return FSM to IDLE, counter cleared, no grant, no rvalid.
REQ-012 On grant edge: addr, we, be, wdata captured; FSM -> RESP_WAIT; latency counter loaded.
REQ-013 Write SHALL update only bytes with be_i=1, on the grant edge; be_i=0 write still returns rvalid.
REQ-014 Read data SHALL be registered and presented on rdata_o in the rvalid cycle; rdata_o holds last value otherwise.
REQ-015 rvalid_o SHALL pulse one cycle exactly RVALID_DELAY cycles after the grant cycle.
REQ-016 In the rvalid cycle a new request MAY be granted (same GNT_DELAY rules), giving one transaction per cycle at GNT_DELAY=0, RVALID_DELAY=1.
REQ-017 Word index = addr_i[ADDR_WIDTH-1:log2(DATA_WIDTH/8)] modulo MEM_WORDS (wrap-around, no error); addr low bits ignored.
REQ-018 Read after write to same word in back-to-back transactions SHALL return the newly written data.

Reset
REQ-019 rst_n=0 SHALL asynchronously force FSM IDLE, counters 0, gnt_o=0, rvalid_o=0, rdata_o=0.
REQ-020 Reset mid-transaction SHALL discard the outstanding transaction; no rvalid after release.
REQ-021 Storage contents SHALL NOT be reset.

Configuration
REQ-022 Macro CORE_MEM_RESPONDER_STALL_EN defined: 8-bit LFSR (taps 8,6,5,4, seed 8'hA5, reset to seed, advances every cycle) SHALL suppress grant in any cycle lfsr[0]=1, extending GNT_WAIT/IDLE.
REQ-023 Macro undefined: no LFSR logic; grant timing purely per GNT_DELAY.

Structure
REQ-024 Shared package core_mem_pkg SHALL hold the FSM state enum, LFSR seed and tap constants.
REQ-025 Storage SHALL be sub-module core_mem_array (single-port, byte-enable write, registered read).

Verification
REQ-026 GNT_DELAY=0, RVALID_DELAY=1: write 0xDEADBEEF to 0x0010 be=4'hF, then read 0x0010 -> gnt same cycle as req, rvalid next cycle, rdata=0xDEADBEEF.
REQ-027 Write 0x11223344 to 0x0020 be=4'hF, write 0xAABBCCDD be=4'b0101, read -> rdata=0x11BB33DD.
REQ-028 GNT_DELAY=3, RVALID_DELAY=4: req held -> gnt 3 cycles after req rises, rvalid 4 cycles after gnt, single pulse.
REQ-029 MEM_WORDS=1024: write 0x5 to 0x0000, read 0x1000 -> rdata=0x5 (wrap).
REQ-030 rst_n=0 for one cycle between grant and rvalid -> no rvalid, gnt_o/rvalid_o=0 during reset, next request served normally.
REQ-031 With CORE_MEM_RESPONDER_STALL_EN: 16 back-to-back reads -> grants occur only in cycles with lfsr[0]=0, all 16 rvalids returned in order.

Source files
------------

// File: rtl/core_mem_pkg.sv
// Shared definitions for the core memory responder: FSM states and stall LFSR constants.
package core_mem_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GNT_WAIT  = 2'd1,
        RESP_WAIT = 2'd2
    } state_e;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LFSR_W = 8;

    // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting toward the MSB.
    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/core_mem_array.sv
// Single-port backing store: byte-enable write, registered read that holds between reads.
module core_mem_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en_i,
    input  logic                          we_i,
    input  logic [$clog2(MEM_WORDS)-1:0]  idx_i,
    input  logic [DATA_WIDTH/8-1:0]       be_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    output logic [DATA_WIDTH-1:0]         rdata_o
);

    localparam int unsigned BE_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    // Storage write; contents are intentionally never reset.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read data only changes on a read access.
    always_comb begin
        rdata_d = rdata_q;
        if (en_i && !we_i) begin
            rdata_d = mem_q[idx_i];
        end
    end

    // Read data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/core_mem_responder.sv
// Memory-side responder for the req/gnt/rvalid core memory protocol.
// Optional grant stalling by an LFSR when CORE_MEM_RESPONDER_STALL_EN is defined.
module core_mem_responder
    import core_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEM_WORDS    = 1024,
    parameter int unsigned GNT_DELAY    = 0,
    parameter int unsigned RVALID_DELAY = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]     data_addr_i,
    input  logic                      data_we_i,
    input  logic [DATA_WIDTH/8-1:0]   data_be_i,
    output logic [DATA_WIDTH-1:0]     data_rdata_o,
    input  logic [DATA_WIDTH-1:0]     data_wdata_i
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   lat_q, lat_d;
    logic               rvalid_q, rvalid_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               we_q, we_d;

    logic               gnt_c;
    logic               free_c;
    logic               stall_c;
    logic [CNT_W-1:0]   cnt_inc;
    logic [IDX_W-1:0]   req_idx;
    logic               txn_we;
    logic               ary_en;
    logic               ary_we;
    logic [IDX_W-1:0]   ary_idx;

    // Word index wraps modulo MEM_WORDS; byte offset bits are dropped.
    assign req_idx = IDX_W'(data_addr_i >> OFF_W);

`ifdef CORE_MEM_RESPONDER_STALL_EN
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    // Free-running stall pattern generator.
    always_comb lfsr_d = lfsr_next(lfsr_q);

    // LFSR register, restarts from the seed on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign stall_c = lfsr_q[0];
`else
    assign stall_c = 1'b0;
`endif

    // Next-state, grant and response timing; the rvalid cycle may accept a new request.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lat_d    = lat_q;
        rvalid_d = 1'b0;
        idx_d    = idx_q;
        we_d     = we_q;
        gnt_c    = 1'b0;
        cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        free_c   = (state_q == IDLE) || ((state_q == RESP_WAIT) && rvalid_q);

        if (free_c) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (data_req_i) begin
                if ((GNT_DELAY == 0) && !stall_c) begin
                    gnt_c = 1'b1;
                end else begin
                    state_d = GNT_WAIT;
                end
            end
        end else if (state_q == GNT_WAIT) begin
            if (!data_req_i) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_inc;
                if ((cnt_inc >= CNT_W'(GNT_DELAY)) && !stall_c) begin
                    gnt_c = 1'b1;
                end
            end
        end else begin
            lat_d    = lat_q - CNT_W'(1);
            rvalid_d = (lat_q == CNT_W'(1));
        end

        if (gnt_c) begin
            state_d  = RESP_WAIT;
            cnt_d    = '0;
            lat_d    = CNT_W'(RVALID_DELAY - 1);
            rvalid_d = (RVALID_DELAY == 1);
            idx_d    = req_idx;
            we_d     = data_we_i;
        end
    end

    // FSM and transaction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lat_q    <= '0;
            rvalid_q <= 1'b0;
            idx_q    <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lat_q    <= lat_d;
            rvalid_q <= rvalid_d;
            idx_q    <= idx_d;
            we_q     <= we_d;
        end
    end

    // Writes commit on the grant edge; reads fetch on the edge that raises rvalid.
    always_comb begin
        txn_we  = gnt_c ? data_we_i : we_q;
        ary_we  = data_gnt_o && data_we_i;
        ary_en  = ary_we || (rvalid_d && !txn_we);
        ary_idx = gnt_c ? req_idx : idx_q;
    end

    core_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (ary_en),
        .we_i    (ary_we),
        .idx_i   (ary_idx),
        .be_i    (data_be_i),
        .wdata_i (data_wdata_i),
        .rdata_o (data_rdata_o)
    );

    // Grant is combinational by protocol; held low while reset is asserted.
    assign data_gnt_o    = gnt_c && rst_n;
    assign data_rvalid_o = rvalid_q;

endmodule
